serial_chunk_adder: RTL and testbench



---
 rtl/serial_chunk_adder_if.sv | 28 ++
 rtl/serial_chunk_adder.sv | 120 ++++++++++++
 tb/tb_serial_chunk_adder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/serial_chunk_adder_if.sv
// Operand/result bundle for serial_chunk_adder; master drives the request, slave returns the result.
// The overflow signal exists only when SERIAL_CHUNK_ADDER_OVF_EN is defined.
interface serial_chunk_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
   logic             overflow;

   modport master (output start, sub, a, b, cin,
                   input  busy, done, sum, carry_out, overflow);
   modport slave  (input  start, sub, a, b, cin,
                   output busy, done, sum, carry_out, overflow);
`else
   modport master (output start, sub, a, b, cin,
                   input  busy, done, sum, carry_out);
   modport slave  (input  start, sub, a, b, cin,
                   output busy, done, sum, carry_out);
`endif
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK-bit ripple slice per clock with a registered carry.
// Optional signed-overflow output enabled by defining SERIAL_CHUNK_ADDER_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; sum/carry_out hold the last result
// RUN   | one chunk added per clock, N = WIDTH/CHUNK clocks
// DONE  | one-cycle done pulse; start ignored
module serial_chunk_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input logic                clk,
   input logic                rst,
   serial_chunk_adder_if.slave bus
);
   localparam int N     = WIDTH / CHUNK;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
         $error("serial_chunk_adder: illegal WIDTH/CHUNK combination");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt, s_ext;
   logic [CHUNK:0]   slice;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (state)
         IDLE: if (bus.start) state_nxt = RUN;
         RUN: begin
            bus.busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      slice = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + (CHUNK+1)'(carry);
      s_ext = WIDTH'(slice[CHUNK-1:0]);
      // new chunk enters at the MSB end so the result is aligned after N shifts
      r_nxt = (r_sh >> CHUNK) | (s_ext << (WIDTH - CHUNK));
      last  = (cnt == CNT_W'(N - 1));
   end

`ifdef SERIAL_CHUNK_ADDER_OVF_EN
   logic c_msb_in;
   logic ovf_q;

   // carry into the top bit of the slice, recovered from its sum and operand bits
   assign c_msb_in     = slice[CHUNK-1] ^ a_sh[CHUNK-1] ^ b_sh[CHUNK-1];
   assign bus.overflow = ovf_q;

   always_ff @(posedge clk) begin
      if (rst)                        ovf_q <= 1'b0;
      else if (state == RUN && last)  ovf_q <= c_msb_in ^ slice[CHUNK];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         r_sh   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh  <= bus.a;
                  b_sh  <= bus.sub ? ~bus.b : bus.b;
                  carry <= bus.sub ? 1'b1 : bus.cin;
                  r_sh  <= '0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> CHUNK;
               b_sh  <= b_sh >> CHUNK;
               r_sh  <= r_nxt;
               carry <= slice[CHUNK];
               cnt   <= cnt + CNT_W'(1);
               if (last) begin
                  sum_q  <= r_nxt;
                  cout_q <= slice[CHUNK];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: CHUNK=1 and CHUNK=4 instances driven in lockstep, checked against a signed/unsigned arithmetic model.
module tb_serial_chunk_adder;
   logic clk = 1'b0;
   logic rst;
   logic start, sub, cin;
   logic [7:0] a, b;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] prev_s1, prev_s4;
   logic       prev_c1, prev_c4;
   logic       prev_o1, prev_o4;

   always #5 clk = ~clk;

   serial_chunk_adder_if #(.WIDTH(8)) if1 ();
   serial_chunk_adder_if #(.WIDTH(8)) if4 ();

   assign if1.start = start;
   assign if1.sub   = sub;
   assign if1.a     = a;
   assign if1.b     = b;
   assign if1.cin   = cin;
   assign if4.start = start;
   assign if4.sub   = sub;
   assign if4.a     = a;
   assign if4.b     = b;
   assign if4.cin   = cin;

   serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input logic mc,
                                 input logic ms, output logic [7:0] s, output logic co,
                                 output logic ov);
      int ua, ub, uc, sa, sb, r;
      ua = int'(ma);
      ub = int'(mb);
      uc = mc ? 1 : 0;
      sa = ma[7] ? ua - 256 : ua;
      sb = mb[7] ? ub - 256 : ub;
      if (ms) begin
         s  = 8'((ua - ub) & 255);
         co = (ua >= ub);
         r  = sa - sb;
      end else begin
         s  = 8'((ua + ub + uc) & 255);
         co = (ua + ub + uc) > 255;
         r  = sa + sb + uc;
      end
      ov = (r > 127) || (r < -128);
   endfunction

   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, input logic ts);
      logic [7:0] es;
      logic       eco, eov;
      model(ta, tb_v, tc, ts, es, eco, eov);
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         start = (j == 2 || j == 3);
         if (j == 1) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         end
         check("busy1", 32'(if1.busy), 32'(j <= 8));
         check("done1", 32'(if1.done), 32'(j == 9));
         check("busy4", 32'(if4.busy), 32'(j <= 2));
         check("done4", 32'(if4.done), 32'(j == 3));
         check("sum1",  32'(if1.sum),       32'((j <= 8) ? prev_s1 : es));
         check("cout1", 32'(if1.carry_out), 32'((j <= 8) ? prev_c1 : eco));
         check("sum4",  32'(if4.sum),       32'((j <= 2) ? prev_s4 : es));
         check("cout4", 32'(if4.carry_out), 32'((j <= 2) ? prev_c4 : eco));
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
         check("ovf1", 32'(if1.overflow), 32'((j <= 8) ? prev_o1 : eov));
         check("ovf4", 32'(if4.overflow), 32'((j <= 2) ? prev_o4 : eov));
`endif
      end
      start = 1'b0;
      prev_s1 = es; prev_s4 = es;
      prev_c1 = eco; prev_c4 = eco;
      prev_o1 = eov; prev_o4 = eov;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_busy1"}, 32'(if1.busy), 32'(0));
      check({tag, "_done1"}, 32'(if1.done), 32'(0));
      check({tag, "_sum1"},  32'(if1.sum), 32'(0));
      check({tag, "_cout1"}, 32'(if1.carry_out), 32'(0));
      check({tag, "_busy4"}, 32'(if4.busy), 32'(0));
      check({tag, "_sum4"},  32'(if4.sum), 32'(0));
      check({tag, "_cout4"}, 32'(if4.carry_out), 32'(0));
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
      check({tag, "_ovf1"}, 32'(if1.overflow), 32'(0));
      check({tag, "_ovf4"}, 32'(if4.overflow), 32'(0));
`endif
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
      prev_s1 = '0; prev_s4 = '0; prev_c1 = 1'b0; prev_c4 = 1'b0; prev_o1 = 1'b0; prev_o4 = 1'b0;
      repeat (2) @(negedge clk);
      check_cleared("reset");
      rst = 1'b0;

      do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b1, 1'b0);
      do_op(8'hFF, 8'h00, 1'b1, 1'b0);
      do_op(8'h10, 8'h20, 1'b0, 1'b1);
      do_op(8'h20, 8'h10, 1'b0, 1'b1);
      do_op(8'hAB, 8'hCD, 1'b0, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0, 1'b0);
      do_op(8'h80, 8'h01, 1'b1, 1'b1);
      do_op(8'h05, 8'h03, 1'b0, 1'b0);

      // reset in the third RUN cycle of the CHUNK=1 instance
      @(negedge clk);
      a = 8'h3C; b = 8'h4D; cin = 1'b1; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_busy1", 32'(if1.busy), 32'(1));
      rst = 1'b1;
      @(negedge clk);
      check_cleared("midrst");
      rst = 1'b0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         check("post_done1", 32'(if1.done), 32'(0));
         check("post_busy1", 32'(if1.busy), 32'(0));
         check("post_sum1",  32'(if1.sum), 32'(0));
      end
      prev_s1 = '0; prev_s4 = '0; prev_c1 = 1'b0; prev_c4 = 1'b0; prev_o1 = 1'b0; prev_o4 = 1'b0;

      for (int i = 0; i < 20; i++)
         do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
